// File: rtl/decimated_sample_streamer.sv
// rtl/decimated_sample_streamer.sv - buffers 16-bit decimated samples and streams them as MSB-first byte pairs
module decimated_sample_streamer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clear,
    input  logic [15:0]                   i_din,
    input  logic                          i_din_valid,
    output logic [7:0]                    o_dout,
    output logic                          o_dout_valid,
    output logic                          o_dout_last,
    input  logic                          i_dout_ack,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND_MSB = 2'd1,
        S_SEND_LSB = 2'd2
    } state_t;

    logic [15:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic [PTR_W:0] r_level;
    logic           r_overflow;
    logic [15:0]    r_hold;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_dout;
    logic           r_dout_valid;
    logic           r_dout_last;

    logic [7:0]     w_dout_nxt;
    logic           w_valid_nxt;
    logic           w_last_nxt;
    logic           w_pop;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic           w_xfer;
    logic [15:0]    w_head;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (identical).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_xfer  = r_dout_valid && i_dout_ack;
    // A pop in the same edge frees the slot the push needs.
    assign w_push  = i_din_valid && !i_clear && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_hold       <= 16'h0000;
        end else if (i_clear) begin
            r_state      <= S_IDLE;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_valid_nxt;
            r_dout_last  <= w_last_nxt;
            if (w_pop) begin
                r_hold <= w_head;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (!w_empty) w_state_nxt = S_SEND_MSB;
            S_SEND_MSB: if (w_xfer)   w_state_nxt = S_SEND_LSB;
            S_SEND_LSB: if (w_xfer)   w_state_nxt = w_empty ? S_IDLE : S_SEND_MSB;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_dout_valid;
        w_last_nxt  = r_dout_last;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_dout_nxt  = w_head[15:8];
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                end
            end
            S_SEND_MSB: begin
                if (w_xfer) begin
                    w_dout_nxt = r_hold[7:0];
                    w_last_nxt = 1'b1;
                end
            end
            S_SEND_LSB: begin
                if (w_xfer) begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_dout_nxt = w_head[15:8];
                        w_last_nxt = 1'b0;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + PTR_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - PTR_ONE;
            end
            if (i_din_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_dout_last  = r_dout_last;
    assign o_overflow   = r_overflow;
    assign o_fifo_level = r_level;

endmodule

// File: tb/tb_decimated_sample_streamer.sv
// tb/tb_decimated_sample_streamer.sv - directed vector bench for decimated_sample_streamer
module tb_decimated_sample_streamer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [15:0] din;
    logic        din_valid;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ack;
    logic        overflow;
    logic [2:0]  fifo_level;

    decimated_sample_streamer #(.FIFO_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_dout_last  (dout_last),
        .i_dout_ack   (dout_ack),
        .o_overflow   (overflow),
        .o_fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [15:0] din;
        logic        ack;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic [2:0]  elev;
        logic        eovf;
    } vec_t;

    localparam int NV = 12;
    vec_t       vecs [NV];
    int         n_chk;
    int         n_fail;
    logic [7:0] got_b [$];
    logic       got_l [$];
    logic [7:0] exp_b [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic dv, logic [15:0] d, logic ack, logic ev,
                                logic [7:0] ed, logic el, logic [2:0] elev, logic eovf);
        vec_t v;
        v.dv = dv; v.din = d; v.ack = ack; v.ev = ev;
        v.ed = ed; v.el = el; v.elev = elev; v.eovf = eovf;
        return v;
    endfunction

    task automatic strobe(input logic [15:0] d);
        din_valid = 1'b1;
        din       = d;
        tick();
        din_valid = 1'b0;
    endtask

    // Collects bytes until dout_valid drops; also checks dout/last hold during stalls.
    task automatic drain(input bit rnd);
        logic       hold;
        logic [7:0] pd;
        logic       pl;
        int         cyc;
        got_b.delete();
        got_l.delete();
        hold = 1'b0;
        pd   = 8'h00;
        pl   = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (hold) begin
                chk("stall dout stable", {24'h0, dout}, {24'h0, pd});
                chk("stall last stable", {31'h0, dout_last}, {31'h0, pl});
            end
            if (!dout_valid && got_b.size() > 0) break;
            dout_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_valid && dout_ack) begin
                got_b.push_back(dout);
                got_l.push_back(dout_last);
            end
            hold = dout_valid && !dout_ack;
            pd   = dout;
            pl   = dout_last;
            tick();
        end
        if (cyc >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain timeout: got %0d bytes after %0d cycles", got_b.size(), cyc);
        end
        dout_ack = 1'b0;
    endtask

    task automatic chk_seq(input string name);
        chk({name, " count"}, got_b.size(), exp_b.size());
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            chk($sformatf("%s byte%0d", name, i), {24'h0, got_b[i]}, {24'h0, exp_b[i]});
            chk($sformatf("%s last%0d", name, i), {31'h0, got_l[i]}, i % 2);
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; dout_ack = 1'b0;

        vecs[0]  = mk(1'b1, 16'hA55A, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        vecs[1]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b0, 3'd0, 1'b0);
        vecs[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd0, 1'b0);
        vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        vecs[4]  = mk(1'b1, 16'h0102, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        vecs[5]  = mk(1'b1, 16'h0304, 1'b1, 1'b1, 8'h01, 1'b0, 3'd1, 1'b0);
        vecs[6]  = mk(1'b1, 16'h0506, 1'b1, 1'b1, 8'h02, 1'b1, 3'd2, 1'b0);
        vecs[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'h03, 1'b0, 3'd1, 1'b0);
        vecs[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'h04, 1'b1, 3'd1, 1'b0);
        vecs[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'h05, 1'b0, 3'd0, 1'b0);
        vecs[10] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'h06, 1'b1, 3'd0, 1'b0);
        vecs[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        repeat (2) tick();
        chk("reset dout", {24'h0, dout}, 0);
        chk("reset valid", {31'h0, dout_valid}, 0);
        chk("reset last", {31'h0, dout_last}, 0);
        chk("reset overflow", {31'h0, overflow}, 0);
        chk("reset level", {29'h0, fifo_level}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            din_valid = vecs[i].dv;
            din       = vecs[i].din;
            dout_ack  = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d valid", i), {31'h0, dout_valid}, {31'h0, vecs[i].ev});
            if (vecs[i].ev) chk($sformatf("vec%0d dout", i), {24'h0, dout}, {24'h0, vecs[i].ed});
            chk($sformatf("vec%0d last", i), {31'h0, dout_last}, {31'h0, vecs[i].el});
            chk($sformatf("vec%0d level", i), {29'h0, fifo_level}, {29'h0, vecs[i].elev});
            chk($sformatf("vec%0d overflow", i), {31'h0, overflow}, {31'h0, vecs[i].eovf});
        end
        din_valid = 1'b0;
        dout_ack  = 1'b0;

        // Stall with overflow: one word held, four stored, sixth dropped.
        for (int k = 1; k <= 6; k++) strobe(16'(k));
        chk("stall level", {29'h0, fifo_level}, 4);
        chk("stall overflow", {31'h0, overflow}, 1);
        chk("stall valid", {31'h0, dout_valid}, 1);
        chk("stall dout", {24'h0, dout}, 8'h00);
        exp_b.delete();
        for (int k = 1; k <= 5; k++) begin
            exp_b.push_back(8'h00);
            exp_b.push_back(8'(k));
        end
        drain(1'b0);
        chk_seq("stall drain");
        chk("overflow sticky", {31'h0, overflow}, 1);

        // Clear after MSB transfer with a same-edge strobe.
        strobe(16'hC3D4);
        tick();
        chk("clr msb", {24'h0, dout}, 8'hC3);
        dout_ack = 1'b1;
        tick();
        chk("clr lsb shown", {24'h0, dout}, 8'hD4);
        dout_ack  = 1'b0;
        clear     = 1'b1;
        din_valid = 1'b1;
        din       = 16'hBEEF;
        tick();
        clear     = 1'b0;
        din_valid = 1'b0;
        chk("clr valid", {31'h0, dout_valid}, 0);
        chk("clr level", {29'h0, fifo_level}, 0);
        chk("clr overflow", {31'h0, overflow}, 0);
        chk("clr last", {31'h0, dout_last}, 0);
        chk("clr dout", {24'h0, dout}, 0);
        dout_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("clr quiet%0d", k), {31'h0, dout_valid}, 0);
        end
        dout_ack = 1'b0;

        // Full FIFO: LSB transfer pops while a new sample is pushed.
        for (int k = 0; k < 5; k++) strobe(16'h1011 + 16'(k) * 16'h0202);
        chk("full level", {29'h0, fifo_level}, 4);
        chk("full overflow", {31'h0, overflow}, 0);
        dout_ack = 1'b1;
        tick();
        chk("full lsb shown", {24'h0, dout}, 8'h11);
        chk("full lsb last", {31'h0, dout_last}, 1);
        strobe(16'h1A1B);
        chk("popush level", {29'h0, fifo_level}, 4);
        chk("popush overflow", {31'h0, overflow}, 0);
        chk("popush dout", {24'h0, dout}, 8'h12);
        exp_b.delete();
        for (int k = 8'h12; k <= 8'h1B; k++) exp_b.push_back(8'(k));
        drain(1'b0);
        chk_seq("popush drain");

        // Random ack stalls.
        dout_ack = 1'b0;
        for (int k = 0; k < 4; k++) strobe(16'h2122 + 16'(k) * 16'h0202);
        exp_b.delete();
        for (int k = 8'h21; k <= 8'h28; k++) exp_b.push_back(8'(k));
        drain(1'b1);
        chk_seq("random drain");

        // Asynchronous reset mid-word.
        for (int k = 0; k < 6; k++) strobe(16'h3132 + 16'(k) * 16'h0202);
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk("prereset dout", {24'h0, dout}, 8'h32);
        chk("prereset overflow", {31'h0, overflow}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async dout", {24'h0, dout}, 0);
        chk("async valid", {31'h0, dout_valid}, 0);
        chk("async last", {31'h0, dout_last}, 0);
        chk("async overflow", {31'h0, overflow}, 0);
        chk("async level", {29'h0, fifo_level}, 0);
        tick();
        rst_n    = 1'b1;
        dout_ack = 1'b1;
        repeat (3) tick();
        chk("postreset valid", {31'h0, dout_valid}, 0);
        chk("postreset level", {29'h0, fifo_level}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decimated_sample_streamer.md
# decimated_sample_streamer

Output stage placed directly downstream of the decimation filter. It captures each 16-bit decimated word on a one-cycle strobe and buffers it in a small FIFO. It then streams each word out as two bytes, MSB first, over an 8-bit valid/ack handshake, so a slow external reader can drain samples without losing them. Overflow is flagged sticky; the sample that arrives when the FIFO is full is dropped.

## Interface

Parameters:
- FIFO_DEPTH, default 4: number of 16-bit words buffered. Must be a power of two, ≥ 2.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- clear  input  1  synchronous flush. Empties the FIFO, aborts any transfer, clears overflow.
- din  input  16  decimated sample from the filter.
- din_valid  input  1  one-cycle strobe; din is valid in the same cycle.
- dout  output  8  byte presented to the reader.
- dout_valid  output  1  dout holds a byte awaiting acceptance.
- dout_last  output  1  high while the LSB byte of a word is presented.
- dout_ack  input  1  reader accepts the byte; a transfer occurs at a rising edge where dout_valid && dout_ack.
- overflow  output  1  sticky; set when a sample is dropped.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words stored. Excludes the word currently being streamed.

## Operation

- Reset values: dout=0, dout_valid=0, dout_last=0, overflow=0, fifo_level=0. FIFO pointers are 0 and the FSM is in IDLE.
- Write: a rising edge with din_valid=1 and clear=0 pushes din if fifo_level<FIFO_DEPTH. If the FIFO is full, the sample is dropped and overflow is set.
- Pointers wrap modulo FIFO_DEPTH. Full/empty detection uses an extra pointer MSB.
- The FSM has three states: IDLE, SEND_MSB, SEND_LSB.
  - IDLE: if fifo_level>0, pop the head word into a 16-bit holding register. Load dout=word[15:8] and set dout_valid=1, dout_last=0. Go to SEND_MSB.
  - SEND_MSB: hold dout stable until the transfer. On transfer, load dout=word[7:0] and set dout_last=1. Go to SEND_LSB.
  - SEND_LSB: on transfer, if fifo_level>0, pop the next word, load its MSB, set dout_last=0, and stay in SEND_MSB flow. Otherwise clear dout_valid and dout_last and go to IDLE.
- Handshake rules:
  - dout and dout_last never change while dout_valid=1 and no transfer has occurred.
  - dout_valid never drops without a transfer, except on clear or reset.
  - dout_ack while dout_valid=0 is ignored.
- Because popping moves the word into the holding register, a full FIFO regains a slot when that pop happens.
- Simultaneous pop and push in one edge: both take effect and fifo_level is unchanged. When this happens at full, the push is accepted and overflow is not set.
- Priority of clear: clear has priority over everything. In that edge the FIFO empties and the FSM goes to IDLE. dout_valid, dout_last and overflow are cleared, and dout=0. A din_valid in the same edge is dropped without setting overflow.
- Only rst_n or clear reset overflow.
- Asserting rst_n low mid-transfer immediately forces all reset values. The partially sent word is lost.

## Timing

- Latency from an empty FIFO with the FSM in IDLE:
  - din_valid sampled at edge N → fifo_level=1 after edge N.
  - At edge N+1 the word is popped → dout_valid=1 with the MSB after edge N+1, and fifo_level=0.
- Throughput: one byte per cycle with dout_ack held high. A word takes 2 cycles and there is no bubble between words while the FIFO is non-empty.
- All outputs are registered. There is no combinational path from dout_ack to any output.

## Test plan

- Single sample: din=16'hA55A strobed once, dout_ack=1.
  - Required: dout_valid rises 2 edges later.
  - Bytes transferred: 8'hA5 (last=0), then 8'h5A (last=1).
  - Afterwards dout_valid=0 and fifo_level=0.
- Back-to-back words: 3 samples 16'h0102, 16'h0304, 16'h0506 on consecutive cycles, ack always high.
  - Required: bytes 01,02,03,04,05,06 on 6 consecutive transfers with no gaps; overflow=0.
- Stall and overflow: dout_ack=0 and 6 strobes 16'h0001..16'h0006 with FIFO_DEPTH=4.
  - Required: the word 0001 sits in the holding register, 0002..0005 are stored, and fifo_level=4.
  - 0006 is dropped and overflow=1.
  - After ack=1, the bytes seen are exactly 00,01,…,00,05.
- Full with simultaneous pop and push: FIFO full, and din_valid occurs on the same edge as an LSB transfer that pops.
  - Required: the push is accepted, overflow stays 0, and fifo_level stays 4.
- Stable data under stall: toggle dout_ack randomly.
  - Required: dout and dout_last are unchanged between transfers, and no byte is duplicated or skipped.
- Clear and reset mid-word: assert clear after the MSB transfer, with din_valid in the same cycle.
  - Required next cycle: dout_valid=0, fifo_level=0, overflow=0, and no LSB is ever emitted.
  - Repeat with rst_n pulsed low asynchronously between edges: all outputs go to 0 immediately.
